stack_sequencer: RTL
====================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter BASE, default 8'hFF: memory address of the first (bottom) stack slot.
REQ-002 Parameter DEPTH, default 16: maximum number of entries, range 1..255; stack grows downward from BASE.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 op  input  2  request code: 00 none, 01 push, 10 pop, 11 peek (read top, no SP change).
REQ-006 req_valid  input  1  request present on op/r0.
REQ-007 req_ready  output  1  sequencer can accept a request this cycle.
REQ-008 r0  input  8  push data, sampled at acceptance.
REQ-009 mem_addr  output  8  stack RAM address.
REQ-010 mem_wdata  output  8  stack RAM write data.
REQ-011 mem_we  output  1  stack RAM write strobe, one cycle per push.
REQ-012 mem_rdata  input  8  stack RAM read data, valid one cycle after mem_addr is presented.
REQ-013 rdata  output  8  popped/peeked value, held until next pop/peek completes.
REQ-014 rdata_valid  output  1  one-cycle pulse when rdata is updated.
REQ-015 sp  output  8  stack pointer: address of next free slot.
REQ-016 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-017 err  output  1  sticky overflow/underflow flag.
REQ-018 err_clr  input  1  synchronous clear of err.

Function
REQ-019 Acceptance occurs on a rising edge with req_valid=1, req_ready=1, op!=00; op=00 with req_valid=1 is ignored.
REQ-020 FSM states: IDLE, WRITE, RD_ADDR, RD_DATA; req_ready=1 only in IDLE.
REQ-021 Push accepted, not full: IDLE->WRITE; in WRITE mem_addr=sp, mem_wdata=latched r0, mem_we=1; at end of WRITE sp<=sp-1, count+1, ->IDLE (2 cycles accept-to-accept).
REQ-022 Pop/peek accepted, not empty: IDLE->RD_ADDR with mem_addr=sp+1 (8-bit wrap); ->RD_DATA; in RD_DATA rdata<=mem_rdata, rdata_valid pulses the following cycle, ->IDLE (3 cycles accept-to-accept).
REQ-023 Pop increments sp and decrements count at the RD_DATA exit edge; peek leaves sp/count unchanged.
REQ-024 Push when full: no memory write, sp/count unchanged, err<=1, FSM stays IDLE (request consumed in 1 cycle).
REQ-025 Pop/peek when empty: no read, no rdata_valid, rdata unchanged, err<=1, stays IDLE.
REQ-026 mem_we=0 in every state except WRITE; mem_addr=sp when IDLE.
REQ-027 sp arithmetic is 8-bit modulo; sp==BASE-count always holds.
REQ-028 err_clr and a new error in the same cycle: err=1 (set wins).
REQ-029 empty/full are combinational from count and reflect the updated count the cycle after the commit edge.

Reset
REQ-030 On rst=1, immediately: state IDLE, sp=BASE, count=0, empty=1, full=0, err=0, mem_we=0, rdata=8'h00, rdata_valid=0, req_ready=1.
REQ-031 rst asserted mid-WRITE or mid-read aborts the operation: no write completes after reset assertion, no rdata_valid pulse, sp returns to BASE.

Verification
REQ-032 Reset then push r0=8'hFA: mem_we=1 for one cycle at mem_addr=8'hFF, wdata=8'hFA; then sp=8'hFE, empty=0.
REQ-033 Push 8'hFA, push 8'hEF, pop, pop: rdata=8'hEF then 8'hFA, two rdata_valid pulses, sp back to 8'hFF, empty=1, err=0.
REQ-034 Push 8'h5A, peek twice: rdata=8'h5A on both pulses, sp stays 8'hFE.
REQ-035 DEPTH=4: five pushes -> full=1 after 4th, 5th produces no mem_we, err=1, sp=8'hFB; err_clr -> err=0.
REQ-036 Pop from empty after reset: no rdata_valid, err=1, sp=8'hFF, rdata=8'h00.
REQ-037 Assert rst during WRITE of a push: mem_we drops immediately, sp=8'hFF, count=0, req_ready=1.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack sequencer: turns push/pop/peek requests into single-port RAM cycles.
// Stack grows downward from BASE; sp always points at the next free slot.
module stack_sequencer #(
  parameter logic [7:0] BASE  = 8'hFF,
  parameter int         DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] r0,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic [7:0] sp,
  output logic       empty,
  output logic       full,
  output logic       err,
  input  logic       err_clr
);

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA
  } state_t;

  typedef struct packed {
    logic       pop;
    logic [7:0] data;
  } req_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] count;
  req_t       held;

  logic accept;
  logic is_push;
  logic is_read;
  logic push_err;
  logic read_err;
  logic err_set;

  assign sp    = BASE - count;
  assign empty = (count == 8'd0);
  assign full  = (count == DEPTH_C);

  assign accept  = (state == IDLE) && req_valid
                 && (op != 2'b00);
  assign is_push = (op == 2'b01);
  assign is_read = op[1];

  // Overflow/underflow consume the request without leaving IDLE.
  assign push_err = accept && is_push && full;
  assign read_err = accept && is_read && empty;
  assign err_set  = push_err || read_err;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = sp;
    mem_wdata = held.data;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        unique case (1'b1)
          accept && is_push && !full:
            state_n = WRITE;
          accept && is_read && !empty:
            state_n = RD_ADDR;
          default:
            state_n = IDLE;
        endcase
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_n = IDLE;
      end
      RD_ADDR: begin
        mem_addr = sp + 8'd1;
        state_n  = RD_DATA;
      end
      RD_DATA: begin
        mem_addr = sp + 8'd1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 8'd0;
      held        <= '0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      rdata_valid <= 1'b0;
      err         <= err_set | (err & ~err_clr);
      if (accept) begin
        held.pop  <= ~op[0];
        held.data <= r0;
      end
      if (state == WRITE) begin
        count <= count + 8'd1;
      end
      if (state == RD_DATA) begin
        rdata       <= mem_rdata;
        rdata_valid <= 1'b1;
        if (held.pop) begin
          count <= count - 8'd1;
        end
      end
    end
  end

endmodule
